// File: rtl/disaggregator_if.sv
// Handshake bundle between an upstream packed-word FIFO, the disaggregator and
// a narrow receiver FIFO. The disaggregator connects through the slave modport.
interface disaggregator_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 2
);
  localparam int FWW = $clog2(FETCH_WIDTH) + 1;

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;
  logic                              change_fetch_width;
  logic [FWW-1:0]                    input_fetch_width;

  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
           change_fetch_width, input_fetch_width,
    input  sender_deq, receiver_data, receiver_enq
  );

  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
           change_fetch_width, input_fetch_width,
    output sender_deq, receiver_data, receiver_enq
  );
endinterface

// File: rtl/disaggregator.sv
// Splits FETCH_WIDTH-lane packed words into single DATA_WIDTH lanes, lane 0 first.
// Optional DISAGGREGATOR_LAST_EN adds the receiver_last output port.
module disaggregator #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  disaggregator_if.slave     bus
`ifdef DISAGGREGATOR_LAST_EN
  ,
  output logic               receiver_last
`endif
);
  localparam int FWW = $clog2(FETCH_WIDTH) + 1;
  localparam int IW  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                                  state_q, state_d;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0]  data_buf_q, data_buf_d;
  logic [IW-1:0]                           idx_q, idx_d;
  logic [FWW-1:0]                          active_fw_q, active_fw_d;
  logic [FWW-1:0]                          pend_fw_q, pend_fw_d;
  logic                                    pend_valid_q, pend_valid_d;

  logic           buf_valid;
  logic           last;
  logic           apply_now;
  logic           enq;
  logic           deq;
  logic [FWW-1:0] req_fw;

  always_comb begin
    buf_valid = (state_q == DRAIN);
    last      = (FWW'(idx_q) == (active_fw_q - FWW'(1)));
    apply_now = pend_valid_q & ~buf_valid;
    enq       = buf_valid & bus.receiver_full_n;
    // A pending width change owns the empty cycle, so no word is taken then.
    deq       = bus.sender_empty_n & (~buf_valid | (enq & last)) & ~apply_now;

    if ((bus.input_fetch_width == '0) ||
        (bus.input_fetch_width > FWW'(FETCH_WIDTH))) begin
      req_fw = FWW'(FETCH_WIDTH);
    end else begin
      req_fw = bus.input_fetch_width;
    end

    state_d      = state_q;
    data_buf_d   = data_buf_q;
    idx_d        = idx_q;
    active_fw_d  = active_fw_q;
    pend_fw_d    = pend_fw_q;
    pend_valid_d = pend_valid_q;

    if (deq) begin
      data_buf_d = bus.sender_data;
      state_d    = DRAIN;
      idx_d      = '0;
    end else if (enq) begin
      if (last) begin
        state_d = EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    if (apply_now) begin
      active_fw_d  = pend_fw_q;
      pend_valid_d = 1'b0;
    end

    // A fresh request in the apply cycle survives as the next pending value.
    if (bus.change_fetch_width) begin
      pend_fw_d    = req_fw;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    bus.receiver_data = data_buf_q[idx_q];
    bus.receiver_enq  = enq;
    bus.sender_deq    = deq;
  end

`ifdef DISAGGREGATOR_LAST_EN
  always_comb begin
    receiver_last = buf_valid & last;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      data_buf_q   <= '0;
      idx_q        <= '0;
      active_fw_q  <= FWW'(FETCH_WIDTH);
      pend_fw_q    <= FWW'(FETCH_WIDTH);
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_buf_q   <= data_buf_d;
      idx_q        <= idx_d;
      active_fw_q  <= active_fw_d;
      pend_fw_q    <= pend_fw_d;
      pend_valid_q <= pend_valid_d;
    end
  end
endmodule

// File: tb/tb_disaggregator.sv
// Self-checking bench for disaggregator: fixed vector table, directed multi-cycle
// sequences and random traffic against a lane-queue reference model.
module tb_disaggregator;
  localparam int DW  = 8;
  localparam int FW  = 2;
  localparam int FWW = $clog2(FW) + 1;

  logic clk = 1'b0;
  logic rst;

  disaggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus ();

`ifdef DISAGGREGATOR_LAST_EN
  logic receiver_last;
`endif

  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DISAGGREGATOR_LAST_EN
    ,
    .receiver_last(receiver_last)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: remaining lanes of the buffered word as a queue.
  logic [DW-1:0]    mq[$];
  logic [FW*DW-1:0] src_q[$];
  logic [DW-1:0]    out_log[$];
  int               m_active = FW;
  int               m_pend   = FW;
  bit               m_pv     = 1'b0;

  task automatic step(input bit r, input bit fn, input bit ch, input int ifw);
    bit ne, xenq, xlast, ap, xdeq, en;
    logic [FW*DW-1:0] w;
    @(negedge clk);
    en = (src_q.size() != 0);
    rst                    = r;
    bus.sender_empty_n     = en;
    bus.sender_data        = en ? src_q[0] : '0;
    bus.receiver_full_n    = fn;
    bus.change_fetch_width = ch;
    bus.input_fetch_width  = FWW'(ifw);
    #1;
    ne    = (mq.size() != 0);
    xenq  = ne & fn;
    xlast = (mq.size() == 1);
    ap    = m_pv & !ne;
    xdeq  = en & (!ne | (xenq & xlast)) & !ap;
    check("enq", bus.receiver_enq, xenq);
    check("deq", bus.sender_deq, xdeq);
    if (xenq) check("data", bus.receiver_data, mq[0]);
`ifdef DISAGGREGATOR_LAST_EN
    check("last", receiver_last, ne & xlast);
`endif
    if (r) begin
      if (xdeq) void'(src_q.pop_front());
      mq.delete();
      m_active = FW;
      m_pv     = 1'b0;
    end else begin
      if (xenq) begin
        out_log.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (xdeq) begin
        w = src_q.pop_front();
        for (int i = 0; i < m_active; i++) mq.push_back(w[i*DW +: DW]);
      end
      if (ap) begin
        m_active = m_pend;
        m_pv     = 1'b0;
      end
      if (ch) begin
        m_pend = (ifw == 0 || ifw > FW) ? FW : ifw;
        m_pv   = 1'b1;
      end
    end
  endtask

  task automatic collect(input int n, input int budget, input bit rnd_full);
    int c = 0;
    while (out_log.size() < n && c < budget) begin
      step(1'b0, rnd_full ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 0);
      c++;
    end
    check("collect_count", out_log.size(), n);
  endtask

  typedef struct {
    bit           en;
    logic [15:0]  sd;
    bit           fn;
    bit           ch;
    logic [1:0]   ifw;
    bit           xdeq;
    bit           xenq;
    logic [7:0]   xd;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit en, input logic [15:0] sd, input bit fn, input bit ch,
                      input logic [1:0] ifw, input bit xdeq, input bit xenq, input logic [7:0] xd);
    vec_t v;
    v = '{en: en, sd: sd, fn: fn, ch: ch, ifw: ifw, xdeq: xdeq, xenq: xenq, xd: xd};
    tbl.push_back(v);
  endtask

  initial begin
    rst                    = 1'b1;
    bus.sender_empty_n     = 1'b0;
    bus.sender_data        = '0;
    bus.receiver_full_n    = 1'b1;
    bus.change_fetch_width = 1'b0;
    bus.input_fetch_width  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_enq", bus.receiver_enq, 1'b0);
    check("rst_deq", bus.sender_deq, 1'b0);
    check("rst_data", bus.receiver_data, '0);
`ifdef DISAGGREGATOR_LAST_EN
    check("rst_last", receiver_last, 1'b0);
`endif

    // Back-to-back order, no bubble between words.
    addv(1, 16'h0100, 1, 0, 0, 1, 0, 8'h00);
    addv(1, 16'h0302, 1, 0, 0, 0, 1, 8'h00);
    addv(1, 16'h0302, 1, 0, 0, 1, 1, 8'h01);
    addv(1, 16'h0504, 1, 0, 0, 0, 1, 8'h02);
    addv(1, 16'h0504, 1, 0, 0, 1, 1, 8'h03);
    addv(0, 16'h0000, 1, 0, 0, 0, 1, 8'h04);
    addv(0, 16'h0000, 1, 0, 0, 0, 1, 8'h05);
    addv(0, 16'h0000, 1, 0, 0, 0, 0, 8'h00);
    // Receiver stalls hold the lane and block the next deq.
    addv(1, 16'h0706, 0, 0, 0, 1, 0, 8'h00);
    addv(1, 16'h0908, 0, 0, 0, 0, 0, 8'h00);
    addv(1, 16'h0908, 1, 0, 0, 0, 1, 8'h06);
    addv(1, 16'h0908, 0, 0, 0, 0, 0, 8'h00);
    addv(1, 16'h0908, 1, 0, 0, 1, 1, 8'h07);
    addv(0, 16'h0000, 1, 0, 0, 0, 1, 8'h08);
    addv(0, 16'h0000, 1, 0, 0, 0, 1, 8'h09);
    addv(0, 16'h0000, 1, 0, 0, 0, 0, 8'h00);
    // Clamp: request 0 then 3, each blocks one deq while applied.
    addv(0, 16'h0000, 1, 1, 0, 0, 0, 8'h00);
    addv(1, 16'h0B0A, 1, 0, 0, 0, 0, 8'h00);
    addv(1, 16'h0B0A, 1, 0, 0, 1, 0, 8'h00);
    addv(0, 16'h0000, 1, 0, 0, 0, 1, 8'h0A);
    addv(0, 16'h0000, 1, 0, 0, 0, 1, 8'h0B);
    addv(0, 16'h0000, 1, 1, 3, 0, 0, 8'h00);
    addv(1, 16'h0D0C, 1, 0, 0, 0, 0, 8'h00);
    addv(1, 16'h0D0C, 1, 0, 0, 1, 0, 8'h00);
    addv(0, 16'h0000, 1, 0, 0, 0, 1, 8'h0C);
    addv(0, 16'h0000, 1, 0, 0, 0, 1, 8'h0D);
    // Width 1: upper lane dropped, every lane is last.
    addv(0, 16'h0000, 1, 1, 1, 0, 0, 8'h00);
    addv(1, 16'h0F0E, 1, 0, 0, 0, 0, 8'h00);
    addv(1, 16'h0F0E, 1, 0, 0, 1, 0, 8'h00);
    addv(1, 16'h1110, 1, 0, 0, 1, 1, 8'h0E);
    addv(0, 16'h0000, 1, 0, 0, 0, 1, 8'h10);
    addv(0, 16'h0000, 1, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst                    = 1'b0;
      bus.sender_empty_n     = tbl[i].en;
      bus.sender_data        = tbl[i].sd;
      bus.receiver_full_n    = tbl[i].fn;
      bus.change_fetch_width = tbl[i].ch;
      bus.input_fetch_width  = tbl[i].ifw;
      #1;
      check($sformatf("tbl%0d_deq", i), bus.sender_deq, tbl[i].xdeq);
      check($sformatf("tbl%0d_enq", i), bus.receiver_enq, tbl[i].xenq);
      if (tbl[i].xenq) check($sformatf("tbl%0d_data", i), bus.receiver_data, tbl[i].xd);
    end

    // Reset mid-word discards lane 1 and restores full width.
    step(1'b1, 1'b1, 1'b0, 0);
    src_q.push_back(16'h0302);
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    rst                 = 1'b0;
    bus.sender_empty_n  = 1'b0;
    bus.receiver_full_n = 1'b1;
    #1;
    check("postrst_enq", bus.receiver_enq, 1'b0);
    check("postrst_deq", bus.sender_deq, 1'b0);
    check("postrst_data", bus.receiver_data, '0);
    out_log.delete();
    src_q.push_back(16'h0706);
    collect(2, 20, 1'b0);
    check("postrst_lane0", out_log[0], 8'h06);
    check("postrst_lane1", out_log[1], 8'h07);

    // Width change requested while a word drains.
    out_log.delete();
    src_q.push_back(16'h0100);
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 1);
    step(1'b0, 1'b1, 1'b0, 0);
    src_q.push_back(16'h0302);
    src_q.push_back(16'h0504);
    collect(4, 20, 1'b0);
    check("inflight_0", out_log[0], 8'h00);
    check("inflight_1", out_log[1], 8'h01);
    check("inflight_2", out_log[2], 8'h02);
    check("inflight_3", out_log[3], 8'h04);
    step(1'b0, 1'b1, 1'b1, 2);
    repeat (2) step(1'b0, 1'b1, 1'b0, 0);

    // Random receiver backpressure on a known stream.
    out_log.delete();
    src_q.push_back(16'h0100);
    src_q.push_back(16'h0302);
    src_q.push_back(16'h0504);
    collect(6, 200, 1'b1);
    for (int i = 0; i < 6; i++) check($sformatf("bp_%0d", i), out_log[i], 8'(i));

    // Random traffic, width changes and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0 && src_q.size() < 4) src_q.push_back(16'($urandom));
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 29) == 0), int'($urandom_range(0, 3)));
    end
    for (int n = 0; n < 100 && (mq.size() != 0 || src_q.size() != 0); n++)
      step(1'b0, 1'b1, 1'b0, 0);
    check("drain_empty", mq.size() + src_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
